// File: rtl/vga_pkg.sv
// Shared VGA mode definitions: logical modes, scaling and window geometry.
// With the default 640x480 raster this gives 320-wide scaled modes and a 40..440 letterbox.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_640x480 = 2'd0,
    MODE_320x240 = 2'd1,
    MODE_320x200 = 2'd2
  } vga_mode_t;

  typedef struct packed {
    logic [9:0] top;
    logic [9:0] bottom;
  } win_t;

  // Letterbox margin is 1/12 of the visible height (40 lines of 480)
  localparam logic [9:0] LBOX_DIV = 10'd12;

  function automatic logic mode_scale2(vga_mode_t m);
    return m != MODE_640x480;
  endfunction

  function automatic logic [9:0] mode_width(vga_mode_t m, logic [9:0] h_disp);
    return mode_scale2(m) ? {1'b0, h_disp[9:1]} : h_disp;
  endfunction

  function automatic win_t mode_window(vga_mode_t m, logic [9:0] v_disp);
    win_t w;
    w.top    = '0;
    w.bottom = v_disp;
    if (m == MODE_320x200) begin
      w.top    = v_disp / LBOX_DIV;
      w.bottom = v_disp - (v_disp / LBOX_DIV);
    end
    return w;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for sync/enable alignment; depth 0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned       DEPTH     = 2,
  parameter int unsigned       WIDTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with frame-boundary mode switching, logical pixel
// coordinates, multiplier-free framebuffer addressing and pipeline-aligned sync.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter logic        HSYNC_POL  = 1'b0,
  parameter logic        VSYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned MODE_INIT  = 2
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic [1:0]        mode_sel,
  input  logic              mode_req,
  output logic              mode_ack,
  output logic [1:0]        mode_cur,
  output logic [9:0]        h_count,
  output logic [9:0]        v_count,
  output logic              fetch_en,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              line_start,
  output logic              frame_start,
  output logic              hsync,
  output logic              vsync,
  output logic              display_enable
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0]  V_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0]  HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [2:0]  SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};
  localparam logic [1:0]  MODE_INIT_BITS = 2'(MODE_INIT);
  localparam vga_mode_t   MODE_RST = vga_mode_t'(MODE_INIT_BITS);

  logic [9:0]        h, v;
  logic              line_end, frame_end;
  vga_mode_t         mode_q, pend_mode;
  logic              pend_valid;
  win_t              win;
  logic              scale2, v_in_win, in_win, second_line;
  logic [9:0]        rel_v;
  logic [ADDR_W-1:0] row_base;
  logic [2:0]        sync_raw, sync_s1, sync_out;

  assign h_count   = h;
  assign v_count   = v;
  assign mode_cur  = mode_q;
  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // A request landing on the swap cycle overwrites pending after the swap, so it waits a frame
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_RST;
      pend_mode  <= MODE_RST;
      pend_valid <= 1'b0;
      mode_ack   <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      if (frame_end && pend_valid) begin
        mode_q     <= pend_mode;
        mode_ack   <= 1'b1;
        pend_valid <= 1'b0;
      end
      if (mode_req && (mode_sel != 2'd3)) begin
        pend_mode  <= vga_mode_t'(mode_sel);
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    win         = mode_window(mode_q, V_DISP);
    scale2      = mode_scale2(mode_q);
    rel_v       = v - win.top;
    v_in_win    = (v >= win.top) && (v < win.bottom);
    in_win      = v_in_win && (h < H_DISP);
    second_line = !scale2 || rel_v[0];
    sync_raw[2] = (h >= HS_START && h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    sync_raw[1] = (v >= VS_START && v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    sync_raw[0] = (h < H_DISP) && (v < V_DISP);
  end

  // row_base is zeroed on the last frame cycle so it reads 0 at the frame-start pixel
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      fetch_en    <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_addr    <= '0;
      row_base    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_s1     <= SYNC_IDLE;
    end else begin
      fetch_en    <= in_win;
      pix_x       <= scale2 ? {1'b0, h[9:1]} : h;
      pix_y       <= scale2 ? {1'b0, rel_v[9:1]} : rel_v;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      sync_s1     <= sync_raw;
      if (in_win) begin
        if (h == '0)
          pix_addr <= row_base;
        else if (!scale2 || !h[0])
          pix_addr <= pix_addr + ADDR_W'(1);
      end
      if (frame_end)
        row_base <= '0;
      else if (line_end && v_in_win && second_line)
        row_base <= row_base + ADDR_W'(mode_width(mode_q, H_DISP));
    end
  end

  vga_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (3),
    .RESET_VAL (SYNC_IDLE)
  ) u_delay (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .din       (sync_s1),
    .dout      (sync_out)
  );

  assign {hsync, vsync, display_enable} = sync_out;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator. It succeeds the fixed 640x480/mode-13h controller with runtime-selectable logical modes, switched only at frame boundaries. It also provides logical pixel coordinates, incremental framebuffer address generation, and sync/enable outputs delayed to align with the framebuffer read pipeline. It sits between the 25 MHz pixel clock domain and the framebuffer read port / DAC output stage.

## Interface
Parameters:
- H_DISPLAY, 640 — visible pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48 — horizontal porches and sync width (pixels)
- V_DISPLAY, 480 — visible lines
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33 — vertical porches and sync width (lines)
- HSYNC_POL, 0 / VSYNC_POL, 0 — active sync level (0 = active-low)
- PIPE_DELAY, 2 — extra cycles applied to hsync/vsync/display_enable (0..7)
- ADDR_W, 19 — framebuffer address width
- MODE_INIT, 2 — mode after reset

Ports:
- clk_25mhz  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- mode_sel  in  2  requested mode: 0 = 640x480 native, 1 = 320x240 2x2, 2 = 320x200 2x2 letterboxed, 3 = reserved
- mode_req  in  1  one-cycle strobe; latches mode_sel as pending
- mode_ack  out  1  one-cycle pulse when pending mode takes effect
- mode_cur  out  2  active mode
- h_count, v_count  out  10  raw counters
- fetch_en  out  1  logical pixel in visible area (framebuffer read strobe)
- pix_x, pix_y  out  10  logical coordinates (valid when fetch_en)
- pix_addr  out  ADDR_W  linear framebuffer address = pix_y*width + pix_x
- line_start  out  1  pulse at h=0 of every line
- frame_start  out  1  pulse at h=0, v=0
- hsync, vsync, display_enable  out  1  delayed outputs for the DAC

## Operation
- h counter wraps at H_TOTAL-1; v increments when h=H_TOTAL-1 and wraps at V_TOTAL-1. Totals are the sums of the four parameters.
- Sync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC) and v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC), driven at the configured polarity.
- Logical window per mode:
  - Mode 0: whole 640x480, scale 1.
  - Mode 1: whole area, scale 2.
  - Mode 2: v in [40, 440), scale 2.
- Address generation uses no multiplier:
  - row_base clears at frame start.
  - Within a window line, pix_addr increments every SCALE pixels, starting from row_base.
  - In scale-2 modes the first scanline of a pair restarts at row_base. After the second scanline, row_base += logical width (640 or 320).
  - pix_x/pix_y are h/v divided by SCALE, with pix_y measured from the window top.
- Mode change:
  - A mode_req with mode_sel≠3 overwrites the pending register and sets the pending flag. mode_sel=3 is ignored.
  - At h=H_TOTAL-1, v=V_TOTAL-1 with pending set: mode_cur ← pending, mode_ack pulses, pending clears. A request arriving in that same cycle is deferred to the next frame.
  - A request equal to mode_cur still acks.

## Timing
- Stage 0 is the counters. fetch_en, pix_x, pix_y, pix_addr, line_start and frame_start are registered, giving 1-cycle latency from the counter position.
- hsync, vsync and display_enable have latency 1+PIPE_DELAY from the counter position. They are delayed through a shift line and are aligned with fetch_en delayed by PIPE_DELAY.
- Reset values:
  - counters 0, mode_cur = MODE_INIT, pending cleared
  - fetch_en, display_enable, line_start, frame_start, mode_ack all 0
  - pix_x, pix_y, pix_addr 0
  - hsync/vsync at the inactive level, including every delay-line stage
- Reset mid-frame aborts immediately. The first frame_start pulse occurs 1 cycle after reset release.

## Structure
- Package vga_pkg: mode enum (MODE_640x480, MODE_320x240, MODE_320x200), per-mode width/scale/window constants, and a function returning window top/bottom for a mode.
- Sub-module vga_delay_line: a parametrised-depth shift register carrying {hsync, vsync, de}, with async reset to a parameterised reset vector. Depth 0 is a wire.

## Test plan
- Reset, defaults (mode 2, PIPE_DELAY=2) -> all outputs at reset values. First frame_start at cycle 1; hsync low for h 656..751 seen 3 cycles late; vsync low on v 490..491.
- Mode 2 pixel walk -> first fetch_en at v=40, h=0; pix_addr 0,0,1,1,…,319,319 on v=40 and repeated on v=41; v=42 starts at 320. Last address is 63999 at v=439, h=639; no fetch_en at v=440.
- Mode 0 walk -> pix_addr increments every cycle; 639 at end of v=0; 307199 at v=479, h=639.
- mode_req (sel=0) at v=100 -> mode_cur unchanged until the last frame cycle; mode_ack pulses once; next frame runs native.
- Two requests in one frame (1 then 0) -> one ack with mode 0; sel=3 -> no ack. A request at the last frame cycle -> applied one frame later.
- Reset asserted mid-line at v=200 -> all outputs immediately at reset values; the delay line is flushed (no stale sync pulse after release).
